reg_write_decoder: RTL and testbench

- Write side of the ARM register file: a 4-to-16 one-hot decoder, a 16 x 32-bit register array, and R15 (PC) update logic.
- Exposes every register on a flattened bus; the 16:1 read multiplexers select from that bus.
- Single write port, plus a dedicated PC path for fetch-stage PC+4 updates.

---
 rtl/reg_write_decoder.sv | 78 +++++++
 tb/tb_reg_write_decoder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/reg_write_decoder.sv
// ARM register-file write side: one-hot write decoder, NREG x WIDTH register array,
// and R15 (PC) update with a priority arbiter and a conflict flag.
module reg_write_decoder #(
    parameter int                WIDTH     = 32,
    parameter int                NREG      = 16,
    parameter int                PC_STEP   = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0,
    localparam int               AW        = $clog2(NREG)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    LE,
    input  logic [AW-1:0]           WR_SEL,
    input  logic [WIDTH-1:0]        DATA_IN,
    input  logic                    PC_LE,
    input  logic [WIDTH-1:0]        PC_IN,
    input  logic                    PC_INC,
    output logic [NREG-1:0]         DEC_OUT,
    output logic [NREG*WIDTH-1:0]   R_ALL,
    output logic [WIDTH-1:0]        PC_OUT,
    output logic                    WR_DONE,
    output logic                    WR_CONFLICT
);

    localparam logic [AW-1:0] PC_IDX = AW'(NREG - 1);

    logic [NREG-1:0][WIDTH-1:0] regs_q, regs_d;
    logic                       done_q, done_d;
    logic                       conflict_q, conflict_d;
    logic                       pc_gen_wr;

    always_comb begin
        DEC_OUT         = '0;
        DEC_OUT[WR_SEL] = LE;
    end

    assign pc_gen_wr = LE && (WR_SEL == PC_IDX);

    // R0..R(NREG-2) are written only through the decoder.
    for (genvar n = 0; n < NREG - 1; n++) begin : g_gpr
        always_comb begin
            regs_d[n] = regs_q[n];
            if (DEC_OUT[n]) regs_d[n] = DATA_IN;
        end
    end

    // PC priority: branch load, then general write, then sequential increment.
    always_comb begin
        regs_d[NREG-1] = regs_q[NREG-1];
        if (PC_LE)
            regs_d[NREG-1] = PC_IN;
        else if (pc_gen_wr)
            regs_d[NREG-1] = DATA_IN;
        else if (PC_INC)
            regs_d[NREG-1] = regs_q[NREG-1] + WIDTH'(PC_STEP);
    end

    assign conflict_d = (PC_LE && pc_gen_wr) || (PC_LE && PC_INC) || (pc_gen_wr && PC_INC);
    assign done_d     = LE || PC_LE || PC_INC;

    always_ff @(posedge CLK) begin
        if (RST) begin
            regs_q     <= {NREG{RESET_VAL}};
            done_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            done_q     <= done_d;
            conflict_q <= conflict_d;
        end
    end

    assign R_ALL       = regs_q;
    assign PC_OUT      = regs_q[NREG-1];
    assign WR_DONE     = done_q;
    assign WR_CONFLICT = conflict_q;

endmodule

// File: tb/tb_reg_write_decoder.sv
// Directed bench for reg_write_decoder: decoder, GPR writes, PC paths, conflicts, reset.
module tb_reg_write_decoder;

    logic          CLK = 1'b0;
    logic          RST, LE, PC_LE, PC_INC;
    logic [3:0]    WR_SEL;
    logic [31:0]   DATA_IN, PC_IN;
    logic [15:0]   DEC_OUT;
    logic [511:0]  R_ALL;
    logic [31:0]   PC_OUT;
    logic          WR_DONE, WR_CONFLICT;

    int checks = 0;
    int failures = 0;

    reg_write_decoder dut (
        .CLK(CLK), .RST(RST), .LE(LE), .WR_SEL(WR_SEL), .DATA_IN(DATA_IN),
        .PC_LE(PC_LE), .PC_IN(PC_IN), .PC_INC(PC_INC), .DEC_OUT(DEC_OUT),
        .R_ALL(R_ALL), .PC_OUT(PC_OUT), .WR_DONE(WR_DONE), .WR_CONFLICT(WR_CONFLICT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rn(input int n);
        return R_ALL[n*32 +: 32];
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        LE = 0; PC_LE = 0; PC_INC = 0; WR_SEL = 0; DATA_IN = 0; PC_IN = 0;
    endtask

    task automatic do_reset();
        RST = 1;
        tick();
        RST = 0;
    endtask

    initial begin
        RST = 1;
        idle();
        tick();
        tick();
        RST = 0;

        // reset state
        for (int n = 0; n < 16; n++) chk($sformatf("rst_R%0d", n), rn(n), 32'h0);
        chk("rst_pc", PC_OUT, 32'h0);
        chk("rst_done", {31'b0, WR_DONE}, 32'h0);
        chk("rst_conf", {31'b0, WR_CONFLICT}, 32'h0);

        // single write to R3; no same-cycle bypass
        LE = 1; WR_SEL = 4'd3; DATA_IN = 32'hDEADBEEF;
        #1;
        chk("dec_r3", {16'b0, DEC_OUT}, 32'h0008);
        chk("r3_nobypass", rn(3), 32'h0);
        tick();
        idle();
        chk("r3_val", rn(3), 32'hDEADBEEF);
        chk("r3_done", {31'b0, WR_DONE}, 32'h1);
        for (int n = 0; n < 16; n++)
            if (n != 3) chk($sformatf("r3_other_R%0d", n), rn(n), 32'h0);
        tick();
        chk("r3_done_pulse", {31'b0, WR_DONE}, 32'h0);

        // sweep R0..R14
        for (int n = 0; n < 15; n++) begin
            LE = 1; WR_SEL = 4'(n); DATA_IN = 32'h100 + 32'(n);
            #1;
            chk($sformatf("dec_sweep%0d", n), {16'b0, DEC_OUT}, 32'h1 << n);
            tick();
            chk($sformatf("sweep_R%0d", n), rn(n), 32'h100 + 32'(n));
        end
        LE = 0; WR_SEL = 4'd5; DATA_IN = 32'hBAD;
        #1;
        chk("dec_le0", {16'b0, DEC_OUT}, 32'h0);
        tick();
        for (int n = 0; n < 15; n++) chk($sformatf("hold_R%0d", n), rn(n), 32'h100 + 32'(n));
        chk("hold_R15", rn(15), 32'h0);
        chk("hold_done", {31'b0, WR_DONE}, 32'h0);
        idle();

        // PC increment and wrap
        do_reset();
        PC_INC = 1;
        tick(); chk("pc_inc1", PC_OUT, 32'h4);
        tick(); chk("pc_inc2", PC_OUT, 32'h8);
        tick(); chk("pc_inc3", PC_OUT, 32'hC);
        PC_INC = 0; PC_LE = 1; PC_IN = 32'hFFFFFFFC;
        tick(); chk("pc_load", PC_OUT, 32'hFFFFFFFC);
        PC_LE = 0; PC_INC = 1;
        tick();
        chk("pc_wrap", PC_OUT, 32'h0);
        chk("pc_wrap_slice", rn(15), 32'h0);
        chk("pc_wrap_done", {31'b0, WR_DONE}, 32'h1);
        idle();

        // three-way and two-way R15 conflicts
        PC_LE = 1; PC_IN = 32'h80; LE = 1; WR_SEL = 4'd15; DATA_IN = 32'h40; PC_INC = 1;
        tick();
        chk("conf3_pc", PC_OUT, 32'h80);
        chk("conf3_flag", {31'b0, WR_CONFLICT}, 32'h1);
        PC_LE = 0;
        tick();
        chk("conf2_pc", PC_OUT, 32'h40);
        chk("conf2_flag", {31'b0, WR_CONFLICT}, 32'h1);
        idle();
        tick();
        chk("conf_clear", {31'b0, WR_CONFLICT}, 32'h0);
        chk("conf_hold_pc", PC_OUT, 32'h40);
        PC_LE = 1; PC_IN = 32'h200; PC_INC = 1;
        tick();
        chk("conf_ldinc_pc", PC_OUT, 32'h200);
        chk("conf_ldinc_flag", {31'b0, WR_CONFLICT}, 32'h1);
        idle();

        // GPR write alongside PC increment: independent, no conflict
        LE = 1; WR_SEL = 4'd7; DATA_IN = 32'h55; PC_INC = 1;
        tick();
        chk("mix_r7", rn(7), 32'h55);
        chk("mix_pc", PC_OUT, 32'h204);
        chk("mix_conf", {31'b0, WR_CONFLICT}, 32'h0);
        idle();

        // reset overrides a same-cycle write
        LE = 1; WR_SEL = 4'd5; DATA_IN = 32'h1234;
        tick();
        chk("pre_rst_r5", rn(5), 32'h1234);
        RST = 1; DATA_IN = 32'hFFFF;
        #1;
        chk("dec_in_rst", {16'b0, DEC_OUT}, 32'h0020);
        tick();
        RST = 0;
        idle();
        chk("rst_r5", rn(5), 32'h0);
        chk("rst_r7", rn(7), 32'h0);
        chk("rst_pc2", PC_OUT, 32'h0);
        chk("rst_done2", {31'b0, WR_DONE}, 32'h0);
        tick();
        chk("post_rst_done", {31'b0, WR_DONE}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
